// File: rtl/rst_release_seq.sv
// rst_release_seq
//   Releases N_STAGE downstream resets one at a time, in index order, after the
//   board reset is released. Each stage has to acknowledge on stage_rdy before
//   the next stage is released. A silent stage is put back into reset and
//   retried, up to MAX_RETRY extra attempts, before the sequencer stops in a
//   sticky error state. A released stage that drops its ready line pulls that
//   stage and every later stage back into reset, and sequencing resumes from
//   the lowest stage that dropped.
//
//   Release/ready handshake: stage_rst_n[k] rising is the request and
//   rdy_s[k] high is the acknowledge. The acknowledge is sampled only while the
//   sequencer waits on stage k. A level that is already high counts as an
//   acknowledge on the first waiting cycle. After that, a low level on any
//   released stage below the current one is treated as loss of that stage.
//
//   Limits: N_STAGE 1..8 (stage index is 3 bits), MAX_RETRY <= 255,
//   DLY_CYC and TMO_CYC in 1..2^32-1.
module rst_release_seq #(
   parameter int N_STAGE   = 4,
   parameter int DLY_CYC   = 1_000,
   parameter int TMO_CYC   = 100_000_000,
   parameter int MAX_RETRY = 3
) (
   input  logic               clk_100M,
   input  logic               rst_n,
   input  logic [N_STAGE-1:0] stage_rdy,
   output logic [N_STAGE-1:0] stage_rst_n,
   output logic               all_rdy,
   output logic               seq_err,
   output logic [2:0]         err_stage,
   output logic [2:0]         o_dbg_state
);

   localparam logic [31:0]        DLY_LAST  = 32'(DLY_CYC - 1);
   localparam logic [31:0]        TMO_LAST  = 32'(TMO_CYC - 1);
   localparam logic [7:0]         RETRY_MAX = 8'(MAX_RETRY);
   localparam logic [2:0]         K_LAST    = 3'(N_STAGE - 1);
   localparam logic [N_STAGE-1:0] ONE       = N_STAGE'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_DLY = 3'd1,
      S_WAIT_RDY = 3'd2,
      S_DONE     = 3'd3,
      S_FAIL     = 3'd4
   } state_t;

   // Synchronisers
   logic               r_rst_meta;
   logic               r_rst_sync;
   logic [N_STAGE-1:0] r_rdy_meta;
   logic [N_STAGE-1:0] r_rdy_sync;

   // Sequencer state and registered outputs
   state_t             r_state;
   logic [31:0]        r_cnt;
   logic [2:0]         r_k;
   logic [7:0]         r_retry;
   logic [N_STAGE-1:0] r_stage_rst_n;
   logic               r_all_rdy;
   logic               r_seq_err;
   logic [2:0]         r_err_stage;

   // Next-state values
   state_t             w_state_nxt;
   logic [31:0]        w_cnt_nxt;
   logic [2:0]         w_k_nxt;
   logic [7:0]         w_retry_nxt;
   logic [N_STAGE-1:0] w_stage_rst_n_nxt;
   logic               w_all_rdy_nxt;
   logic               w_seq_err_nxt;
   logic [2:0]         w_err_stage_nxt;

   // Decode helpers
   logic [N_STAGE-1:0] w_k_onehot;
   logic [N_STAGE-1:0] w_below_k;
   logic [N_STAGE-1:0] w_mon_mask;
   logic [N_STAGE-1:0] w_lost;
   logic               w_loss_any;
   logic [2:0]         w_loss_idx;
   logic [N_STAGE-1:0] w_keep_mask;
   logic               w_rdy_k;

   // Reset release is synchronised; assertion stays asynchronous
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   // Two-flop synchroniser for the asynchronous per-stage ready lines
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_meta <= '0;
         r_rdy_sync <= '0;
      end else begin
         r_rdy_meta <= stage_rdy;
         r_rdy_sync <= r_rdy_meta;
      end
   end

   assign w_k_onehot = ONE << r_k;
   assign w_below_k  = w_k_onehot - ONE;
   assign w_rdy_k    = |(r_rdy_sync & w_k_onehot);

   // Which released stages are watched for loss of ready in the current state
   always_comb begin
      w_mon_mask = '0;
      case (r_state)
         S_WAIT_DLY, S_WAIT_RDY: w_mon_mask = w_below_k;
         S_DONE:                 w_mon_mask = '1;
         default:                w_mon_mask = '0;
      endcase
   end

   assign w_lost     = r_stage_rst_n & ~r_rdy_sync & w_mon_mask;
   assign w_loss_any = |w_lost;

   // Lowest stage index that lost ready
   always_comb begin
      w_loss_idx = '0;
      for (int i = N_STAGE - 1; i >= 0; i--) begin
         if (w_lost[i]) begin
            w_loss_idx = 3'(i);
         end
      end
   end

   // Stages strictly below the lost one stay released
   assign w_keep_mask = (ONE << w_loss_idx) - ONE;

   // Next-state and output logic; ready loss overrides timeout and advance
   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_k_nxt           = r_k;
      w_retry_nxt       = r_retry;
      w_stage_rst_n_nxt = r_stage_rst_n;
      w_all_rdy_nxt     = r_all_rdy;
      w_seq_err_nxt     = r_seq_err;
      w_err_stage_nxt   = r_err_stage;

      if (w_loss_any) begin
         w_stage_rst_n_nxt = r_stage_rst_n & w_keep_mask;
         w_all_rdy_nxt     = 1'b0;
         w_k_nxt           = w_loss_idx;
         w_cnt_nxt         = '0;
         w_retry_nxt       = '0;
         w_state_nxt       = S_WAIT_DLY;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_rst_sync) begin
                  w_cnt_nxt   = '0;
                  w_k_nxt     = '0;
                  w_state_nxt = S_WAIT_DLY;
               end
            end

            S_WAIT_DLY: begin
               if (r_cnt == DLY_LAST) begin
                  w_stage_rst_n_nxt = r_stage_rst_n | w_k_onehot;
                  w_cnt_nxt         = '0;
                  w_state_nxt       = S_WAIT_RDY;
               end else begin
                  w_cnt_nxt = r_cnt + 32'd1;
               end
            end

            S_WAIT_RDY: begin
               if (w_rdy_k) begin
                  w_retry_nxt = '0;
                  w_cnt_nxt   = '0;
                  if (r_k == K_LAST) begin
                     w_all_rdy_nxt = 1'b1;
                     w_state_nxt   = S_DONE;
                  end else begin
                     w_k_nxt     = r_k + 3'd1;
                     w_state_nxt = S_WAIT_DLY;
                  end
               end else if (r_cnt == TMO_LAST) begin
                  w_stage_rst_n_nxt = r_stage_rst_n & ~w_k_onehot;
                  w_cnt_nxt         = '0;
                  if (r_retry < RETRY_MAX) begin
                     w_retry_nxt = r_retry + 8'd1;
                     w_state_nxt = S_WAIT_DLY;
                  end else begin
                     w_seq_err_nxt   = 1'b1;
                     w_err_stage_nxt = r_k;
                     w_state_nxt     = S_FAIL;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 32'd1;
               end
            end

            S_DONE: begin
               w_cnt_nxt = '0;
            end

            S_FAIL: begin
               w_state_nxt = S_FAIL;
            end

            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // Sequencer state register
   always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_k           <= '0;
         r_retry       <= '0;
         r_stage_rst_n <= '0;
         r_all_rdy     <= 1'b0;
         r_seq_err     <= 1'b0;
         r_err_stage   <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_k           <= w_k_nxt;
         r_retry       <= w_retry_nxt;
         r_stage_rst_n <= w_stage_rst_n_nxt;
         r_all_rdy     <= w_all_rdy_nxt;
         r_seq_err     <= w_seq_err_nxt;
         r_err_stage   <= w_err_stage_nxt;
      end
   end

   assign stage_rst_n = r_stage_rst_n;
   assign all_rdy     = r_all_rdy;
   assign seq_err     = r_seq_err;
   assign err_stage   = r_err_stage;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rst_release_seq.sv
// tb_rst_release_seq: checks rst_release_seq with N_STAGE=3, DLY_CYC=10,
// TMO_CYC=50, MAX_RETRY=2 against fixed timing vectors, hand-written corner
// sequences and a per-cycle reference model under random ready behaviour.
module tb_rst_release_seq;

   localparam int N   = 3;
   localparam int DLY = 10;
   localparam int TMO = 50;
   localparam int MR  = 2;

   localparam int PH_BOOT  = 0;
   localparam int PH_DELAY = 1;
   localparam int PH_ACK   = 2;
   localparam int PH_DONE  = 3;
   localparam int PH_DEAD  = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] stage_rdy = '0;
   logic [N-1:0] stage_rst_n;
   logic         all_rdy;
   logic         seq_err;
   logic [2:0]   err_stage;
   logic [2:0]   dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_n    = 0;
   int rel_cyc  = 0;

   // Reference model: number of released stages plus what the sequencer is doing
   int            m_boot;
   int            m_phase;
   int            m_lvl;
   int            m_timer;
   int            m_tries;
   int            m_err_k;
   logic [N-1:0]  m_rq[$];

   // Stimulus helpers
   logic [N-1:0]  prev_rst = '0;
   int            rise_cnt[N];
   int            rel_age[N];
   int            resp_dly[N];
   bit            resp_auto[N];
   bit            rand_en = 1'b0;
   int            stuck = N;

   rst_release_seq #(
      .N_STAGE  (N),
      .DLY_CYC  (DLY),
      .TMO_CYC  (TMO),
      .MAX_RETRY(MR)
   ) dut (
      .clk_100M   (clk),
      .rst_n      (rst_n),
      .stage_rdy  (stage_rdy),
      .stage_rst_n(stage_rst_n),
      .all_rdy    (all_rdy),
      .seq_err    (seq_err),
      .err_stage  (err_stage),
      .o_dbg_state(dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic model_reset();
      m_boot  = 0;
      m_phase = PH_BOOT;
      m_lvl   = 0;
      m_timer = 0;
      m_tries = 0;
      m_err_k = 0;
      m_rq    = {};
      m_rq.push_back('0);
      m_rq.push_back('0);
   endtask

   // One clock edge of the model; rin is stage_rdy as seen on this edge
   task automatic model_step(input logic [N-1:0] rin);
      logic [N-1:0] rs;
      int mon;
      int j;
      int k;
      rs = m_rq.pop_front();
      m_rq.push_back(rin);
      if (m_phase == PH_BOOT) begin
         if (m_boot < 2) m_boot++;
         else begin
            m_phase = PH_DELAY;
            m_timer = 0;
            m_lvl   = 0;
         end
         return;
      end
      mon = (m_phase == PH_DELAY) ? m_lvl :
            (m_phase == PH_ACK)   ? m_lvl - 1 :
            (m_phase == PH_DONE)  ? N : 0;
      j = -1;
      for (int i = mon - 1; i >= 0; i--) begin
         if (!rs[i]) j = i;
      end
      if (j >= 0) begin
         m_lvl   = j;
         m_timer = 0;
         m_tries = 0;
         m_phase = PH_DELAY;
         return;
      end
      case (m_phase)
         PH_DELAY: begin
            if (m_timer == DLY - 1) begin
               m_lvl++;
               m_timer = 0;
               m_phase = PH_ACK;
            end else m_timer++;
         end
         PH_ACK: begin
            k = m_lvl - 1;
            if (rs[k]) begin
               m_tries = 0;
               m_timer = 0;
               m_phase = (k == N - 1) ? PH_DONE : PH_DELAY;
            end else if (m_timer == TMO - 1) begin
               m_lvl--;
               m_timer = 0;
               if (m_tries < MR) begin
                  m_tries++;
                  m_phase = PH_DELAY;
               end else begin
                  m_phase = PH_DEAD;
                  m_err_k = k;
               end
            end else m_timer++;
         end
         default: ;
      endcase
   endtask

   task automatic compare_model();
      logic [N-1:0] e_rst;
      e_rst = N'((1 << m_lvl) - 1);
      check("model stage_rst_n", 32'(stage_rst_n), 32'(e_rst));
      check("model all_rdy", 32'(all_rdy), (m_phase == PH_DONE) ? 32'd1 : 32'd0);
      check("model seq_err", 32'(seq_err), (m_phase == PH_DEAD) ? 32'd1 : 32'd0);
      check("model err_stage", 32'(err_stage), (m_phase == PH_DEAD) ? 32'(m_err_k) : 32'd0);
   endtask

   // Release tracking and ready responders, run just after each edge
   task automatic track();
      for (int i = 0; i < N; i++) begin
         if (stage_rst_n[i] && !prev_rst[i]) rise_cnt[i]++;
         if (stage_rst_n[i]) rel_age[i]++;
         else rel_age[i] = -1;
         prev_rst[i] = stage_rst_n[i];
         if (resp_auto[i]) begin
            stage_rdy[i] = (resp_dly[i] < 0) ? 1'b1 : (rel_age[i] >= resp_dly[i]);
         end else if (rand_en) begin
            if (i == stuck) stage_rdy[i] = 1'b0;
            else if (!stage_rdy[i]) begin
               if ($urandom_range(0, 11) == 0) stage_rdy[i] = 1'b1;
            end else if ($urandom_range(0, 79) == 0) stage_rdy[i] = 1'b0;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      cyc_n++;
      if (rst_n) model_step(stage_rdy);
      #1;
      compare_model();
      track();
   endtask

   task automatic set_resp(input bit a0, input bit a1, input bit a2, input int d);
      resp_auto[0] = a0;
      resp_auto[1] = a1;
      resp_auto[2] = a2;
      for (int i = 0; i < N; i++) resp_dly[i] = d;
   endtask

   // Mid-cycle reset pulse; outputs must clear with no clock edge
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async stage_rst_n", 32'(stage_rst_n), 32'd0);
      check("async all_rdy", 32'(all_rdy), 32'd0);
      check("async seq_err", 32'(seq_err), 32'd0);
      check("async err_stage", 32'(err_stage), 32'd0);
      check("dbg_state known", {31'd0, $isunknown(dbg_state)}, 32'd0);
      for (int i = 0; i < N; i++) rise_cnt[i] = 0;
      cyc();
      cyc();
      rel_cyc = cyc_n;
      rst_n   = 1'b1;
   endtask

   function automatic logic sig_val(input int sel, input int idx);
      case (sel)
         0:       return stage_rst_n[idx];
         1:       return all_rdy;
         default: return seq_err;
      endcase
   endfunction

   task automatic wait_sig(input string name, input int sel, input int idx, input logic val,
                           input int budget, output int at);
      int n;
      n  = 0;
      at = -1;
      while (n < budget) begin
         if (sig_val(sel, idx) === val) begin
            at = cyc_n;
            return;
         end
         cyc();
         n++;
      end
      n_checks++;
      n_errors++;
      $display("FAIL %s: no event within %0d cycles, required value %0d", name, budget, val);
   endtask

   typedef struct {
      int dly;        // cycles from release to stage_rdy high; -1 = high throughout
      int exp_first;  // clock edges from rst_n release to stage_rst_n[0] high
      int exp_gap;    // cycles between consecutive stage releases
      int exp_all;    // cycles from stage_rst_n[2] high to all_rdy high
   } vec_t;

   initial begin
      vec_t tbl[4];
      int   t0, t1, t2, t3;

      tbl[0] = '{5,  13, 18, 8};
      tbl[1] = '{0,  13, 13, 3};
      tbl[2] = '{12, 13, 25, 15};
      tbl[3] = '{-1, 13, 11, 1};

      for (int i = 0; i < N; i++) begin
         rel_age[i]   = -1;
         rise_cnt[i]  = 0;
         resp_dly[i]  = 5;
         resp_auto[i] = 1'b1;
      end

      // Normal sequencing for several ready latencies
      for (int v = 0; v < 4; v++) begin
         set_resp(1, 1, 1, tbl[v].dly);
         do_reset();
         wait_sig("vec rise0", 0, 0, 1'b1, 100, t0);
         check("vec first release", 32'(t0 - rel_cyc), 32'(tbl[v].exp_first));
         wait_sig("vec rise1", 0, 1, 1'b1, 100, t1);
         check("vec gap 0->1", 32'(t1 - t0), 32'(tbl[v].exp_gap));
         wait_sig("vec rise2", 0, 2, 1'b1, 100, t2);
         check("vec gap 1->2", 32'(t2 - t1), 32'(tbl[v].exp_gap));
         wait_sig("vec all_rdy", 1, 0, 1'b1, 100, t3);
         check("vec all_rdy delay", 32'(t3 - t2), 32'(tbl[v].exp_all));
      end

      // Timeout on stage 1, then success on the retry
      set_resp(1, 0, 1, 5);
      stage_rdy[1] = 1'b0;
      do_reset();
      wait_sig("t2 rise1", 0, 1, 1'b1, 100, t1);
      wait_sig("t2 drop1", 0, 1, 1'b0, 100, t2);
      check("t2 timeout drop", 32'(t2 - t1), 32'(TMO));
      wait_sig("t2 rerise1", 0, 1, 1'b1, 100, t3);
      check("t2 re-release", 32'(t3 - t2), 32'(DLY));
      repeat (5) cyc();
      stage_rdy[1] = 1'b1;
      wait_sig("t2 all_rdy", 1, 0, 1'b1, 200, t0);
      check("t2 seq_err", 32'(seq_err), 32'd0);
      check("t2 attempts", 32'(rise_cnt[1]), 32'd2);

      // Stage 1 never ready: retries exhausted
      set_resp(1, 0, 1, 5);
      stage_rdy[1] = 1'b0;
      do_reset();
      wait_sig("t3 seq_err", 2, 0, 1'b1, 400, t0);
      check("t3 attempts", 32'(rise_cnt[1]), 32'(MR + 1));
      check("t3 err_stage", 32'(err_stage), 32'd1);
      check("t3 stage_rst_n", 32'(stage_rst_n), 32'b001);
      repeat (30) cyc();
      check("t3 held stage_rst_n", 32'(stage_rst_n), 32'b001);
      check("t3 held seq_err", 32'(seq_err), 32'd1);
      check("t3 no more attempts", 32'(rise_cnt[1]), 32'(MR + 1));

      // Ready loss of stage 1 in DONE
      set_resp(1, 1, 1, 5);
      do_reset();
      wait_sig("t4 all_rdy", 1, 0, 1'b1, 200, t0);
      resp_auto[1] = 1'b0;
      stage_rdy[1] = 1'b0;
      cyc();
      cyc();
      check("t4 before loss seen", 32'(stage_rst_n), 32'b111);
      cyc();
      t1 = cyc_n;
      check("t4 loss stage_rst_n", 32'(stage_rst_n), 32'b001);
      check("t4 loss all_rdy", 32'(all_rdy), 32'd0);
      resp_auto[1] = 1'b1;
      wait_sig("t4 rerise1", 0, 1, 1'b1, 100, t2);
      check("t4 re-release 1", 32'(t2 - t1), 32'(DLY));
      wait_sig("t4 all_rdy back", 1, 0, 1'b1, 200, t3);

      // Reset while waiting on stage 1
      set_resp(1, 0, 1, 5);
      stage_rdy[1] = 1'b0;
      do_reset();
      wait_sig("t5 rise1", 0, 1, 1'b1, 100, t1);
      repeat (5) cyc();
      set_resp(1, 1, 1, 5);
      do_reset();
      wait_sig("t5 rise0", 0, 0, 1'b1, 100, t0);
      check("t5 restart time", 32'(t0 - rel_cyc), 32'd13);
      check("t5 restart from 0", 32'(stage_rst_n), 32'b001);
      wait_sig("t5 all_rdy", 1, 0, 1'b1, 200, t3);

      // Stages 0 and 2 lose ready on the same cycle in DONE
      set_resp(1, 1, 1, 5);
      do_reset();
      wait_sig("t6 all_rdy", 1, 0, 1'b1, 200, t0);
      resp_auto[0] = 1'b0;
      resp_auto[2] = 1'b0;
      stage_rdy[0] = 1'b0;
      stage_rdy[2] = 1'b0;
      repeat (3) cyc();
      t1 = cyc_n;
      check("t6 loss stage_rst_n", 32'(stage_rst_n), 32'b000);
      check("t6 loss all_rdy", 32'(all_rdy), 32'd0);
      resp_auto[0] = 1'b1;
      resp_auto[2] = 1'b1;
      wait_sig("t6 rerise0", 0, 0, 1'b1, 100, t2);
      check("t6 re-release 0", 32'(t2 - t1), 32'(DLY));
      wait_sig("t6 all_rdy back", 1, 0, 1'b1, 200, t3);

      // Random ready behaviour, checked every cycle by the model
      set_resp(0, 0, 0, 0);
      rand_en = 1'b1;
      for (int s = 0; s < 6; s++) begin
         stuck     = $urandom_range(0, N);
         stage_rdy = N'($urandom_range(0, (1 << N) - 1));
         do_reset();
         repeat (400) cyc();
      end
      rand_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
